width_downsizer: RTL and testbench



---
 rtl/width_downsizer.sv | 112 +++++++++++
 tb/tb_width_downsizer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/width_downsizer.sv
// Purpose : splits one IN_W-bit word into up to IN_W/OUT_W OUT_W-bit beats, LS chunk first.
// Latency : first beat appears the cycle after the word is accepted; one beat per cycle sustained.
// Backpressure: out_ready low freezes all state and holds in_ready low; a new word loads on the last beat's edge.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     input word handshake; in_ready never depends on in_valid
//   in_data[IN_W]         word to split
//   in_len[LW]            beats to emit; 0 means all RATIO beats, k means k beats
//   out_valid/out_ready   beat handshake; out_valid is registered
//   out_data[OUT_W]       current beat, driven from registers only
//   out_last              current beat is the final one of its word
module width_downsizer #(
  parameter  int IN_W  = 32,
  parameter  int OUT_W = 16,
  localparam int RATIO = IN_W / OUT_W,
  localparam int LW    = $clog2(RATIO)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [LW-1:0]    in_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  // Non-integral or sub-2 ratios make the beat index meaningless; stop elaboration.
  if ((IN_W % OUT_W) != 0 || (IN_W / OUT_W) < 2) begin : g_bad_ratio
    $fatal(1, "FAILED -- bad ratio");
  end

  localparam logic [LW:0]   NB_FULL = (LW+1)'(RATIO);
  localparam logic [LW:0]   ONE_W   = (LW+1)'(1);
  localparam logic [LW-1:0] ONE_I   = LW'(1);

  logic              busy_q,      busy_d;
  logic              out_valid_q, out_valid_d;
  logic [LW-1:0]     idx_q,       idx_d;
  logic [LW:0]       nbeats_q,    nbeats_d;
  logic [IN_W-1:0]   hold_q,      hold_d;

  logic              accept;
  logic              beat_xfer;
  logic [LW:0]       idx_ext;
  logic [LW:0]       last_idx;
  logic [OUT_W-1:0]  beat [RATIO];

  // Slice the held word into beats once so the output mux is a plain index.
  for (genvar i = 0; i < RATIO; i++) begin : g_beat
    assign beat[i] = hold_q[i*OUT_W +: OUT_W];
  end

  // Compare at LW+1 bits: nbeats can equal RATIO, which does not fit in LW bits.
  assign idx_ext   = {1'b0, idx_q};
  assign last_idx  = nbeats_q - ONE_W;
  assign out_last  = (idx_ext == last_idx);
  assign out_data  = beat[idx_q];
  assign out_valid = out_valid_q;

  assign beat_xfer = out_valid_q & out_ready;
  assign in_ready  = rst_n & (~busy_q | (out_valid_q & out_ready & out_last));
  assign accept    = in_valid & in_ready;

  always_comb begin
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    nbeats_d    = nbeats_q;
    hold_d      = hold_q;

    if (beat_xfer) begin
      if (!out_last) begin
        // Not last means idx < nbeats-1 <= RATIO-1, so LW bits cannot wrap here.
        idx_d = idx_q + ONE_I;
      end else begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        idx_d       = '0;
      end
    end

    // A word arriving on the last beat's edge overrides the drain above: no bubble.
    if (accept) begin
      hold_d      = in_data;
      nbeats_d    = (in_len == '0) ? NB_FULL : {1'b0, in_len};
      idx_d       = '0;
      busy_d      = 1'b1;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      nbeats_q    <= '0;
      hold_q      <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      nbeats_q    <= nbeats_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_width_downsizer.sv
// Purpose : checks width_downsizer at 32->16 (lane 0) and 32->8 (lane 1) against a beat-queue model.
// Latency : model expects the first beat one cycle after acceptance.
// Backpressure: model expects in_ready only when idle or when the final beat is being taken.
module tb_width_downsizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic [1:0]  in_len    [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_data  [2];
  logic        out_last  [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int OW = (g == 0) ? 16 : 8;
    localparam int R  = 32 / OW;
    localparam int L  = $clog2(R);

    logic [OW-1:0] od;
    logic [16:0]   q[$];   // {last, beat zero-extended to 16 bits}

    width_downsizer #(.IN_W(32), .OUT_W(OW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_len    (in_len[g][L-1:0]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (od),
      .out_last  (out_last[g])
    );
    assign out_data[g] = 16'(od);

    function automatic bit exp_rdy();
      return rst_n && (q.size() == 0 || (q.size() == 1 && out_ready[g]));
    endfunction

    // Model: a word becomes a list of pending beats; a handshake pops the front.
    always @(posedge clk) begin
      if (!rst_n) begin
        q.delete();
      end else begin
        bit pop, push;
        pop  = (q.size() != 0) && out_ready[g];
        push = in_valid[g] && exp_rdy();
        if (pop) void'(q.pop_front());
        if (push) begin
          int n;
          n = (in_len[g][L-1:0] == 0) ? R : int'(in_len[g][L-1:0]);
          for (int b = 0; b < n; b++) begin
            logic [31:0] w;
            w = (in_data[g] >> (b * OW)) & ((32'd1 << OW) - 32'd1);
            q.push_back({(b == n - 1), w[15:0]});
          end
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("lane%0d out_valid", g), 32'(out_valid[g]), 32'(q.size() != 0));
        chk($sformatf("lane%0d in_ready", g), 32'(in_ready[g]), 32'(exp_rdy()));
        if (q.size() != 0) begin
          chk($sformatf("lane%0d out_data", g), 32'(out_data[g]), 32'(q[0][15:0]));
          chk($sformatf("lane%0d out_last", g), 32'(out_last[g]), 32'(q[0][16]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_is(input int g, input string name, input logic [15:0] d, input logic last);
    chk({name, " valid"}, 32'(out_valid[g]), 32'd1);
    chk({name, " data"},  32'(out_data[g]),  32'(d));
    chk({name, " last"},  32'(out_last[g]),  32'(last));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      in_valid[g]  = 1'b0;
      in_data[g]   = '0;
      in_len[g]    = '0;
      out_ready[g] = 1'b1;
    end

    // Reset, then release with no traffic.
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready[0]), 32'd0);
    chk("rst out_valid", 32'(out_valid[0]), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle in_ready", 32'(in_ready[0]), 32'd1);
    chk("idle out_valid", 32'(out_valid[0]), 32'd0);

    // Full word, two beats.
    in_valid[0] = 1'b1; in_data[0] = 32'h1234_abcd; in_len[0] = 2'd0;
    step();
    in_valid[0] = 1'b0;
    @(negedge clk);
    beat_is(0, "full b0", 16'habcd, 1'b0);
    chk("full b0 in_ready", 32'(in_ready[0]), 32'd0);
    step();
    @(negedge clk);
    beat_is(0, "full b1", 16'h1234, 1'b1);
    chk("full b1 in_ready", 32'(in_ready[0]), 32'd1);
    step();

    // Truncated to one beat: upper half never shown.
    in_valid[0] = 1'b1; in_len[0] = 2'd1;
    step();
    in_valid[0] = 1'b0;
    @(negedge clk);
    beat_is(0, "trunc b0", 16'habcd, 1'b1);
    step();
    @(negedge clk);
    chk("trunc done", 32'(out_valid[0]), 32'd0);

    // Back-to-back words, no bubble.
    in_valid[0] = 1'b1; in_data[0] = 32'h0000_ffff; in_len[0] = 2'd0;
    step();
    in_data[0] = 32'hffff_0000;
    @(negedge clk);
    beat_is(0, "b2b 0", 16'hffff, 1'b0);
    step();
    @(negedge clk);
    beat_is(0, "b2b 1", 16'h0000, 1'b1);
    step();
    in_valid[0] = 1'b0;
    @(negedge clk);
    beat_is(0, "b2b 2", 16'h0000, 1'b0);
    step();
    @(negedge clk);
    beat_is(0, "b2b 3", 16'hffff, 1'b1);
    step();
    @(negedge clk);
    chk("b2b done", 32'(out_valid[0]), 32'd0);

    // Stall three cycles on the first beat.
    in_valid[0] = 1'b1; in_data[0] = 32'hcafe_f00d;
    step();
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      beat_is(0, "stall", 16'hf00d, 1'b0);
      chk("stall in_ready", 32'(in_ready[0]), 32'd0);
      step();
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    beat_is(0, "stall rel b0", 16'hf00d, 1'b0);
    step();
    @(negedge clk);
    beat_is(0, "stall rel b1", 16'hcafe, 1'b1);
    step();

    // Reset while the second beat is pending.
    in_valid[0] = 1'b1; in_data[0] = 32'h1234_abcd; in_len[0] = 2'd0;
    step();
    in_valid[0] = 1'b0;
    @(negedge clk);
    beat_is(0, "pre-rst b0", 16'habcd, 1'b0);
    step();
    out_ready[0] = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mid-rst in_ready", 32'(in_ready[0]), 32'd0);
    step();
    rst_n = 1'b1; out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post-rst out_valid", 32'(out_valid[0]), 32'd0);
      step();
    end

    // 32 -> 8, full word then a three-beat truncation.
    in_valid[1] = 1'b1; in_data[1] = 32'hdead_beef; in_len[1] = 2'd0;
    step();
    in_len[1] = 2'd3;
    @(negedge clk);
    beat_is(1, "n8 b0", 16'h00ef, 1'b0);
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    beat_is(1, "n8 b1", 16'h00be, 1'b0);
    step();
    @(negedge clk);
    beat_is(1, "n8 b2", 16'h00ad, 1'b0);
    step();
    @(negedge clk);
    beat_is(1, "n8 b3", 16'h00de, 1'b1);
    step();
    @(negedge clk);
    chk("n8 idle", 32'(out_valid[1]), 32'd0);
    in_valid[1] = 1'b1;
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    beat_is(1, "n8t b0", 16'h00ef, 1'b0);
    step();
    @(negedge clk);
    beat_is(1, "n8t b1", 16'h00be, 1'b0);
    step();
    @(negedge clk);
    beat_is(1, "n8t b2", 16'h00ad, 1'b1);
    step();
    @(negedge clk);
    chk("n8t done", 32'(out_valid[1]), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
